uart_program_loader: RTL
========================

// Module: uart_program_loader
// PURPOSE
//  Receive-side counterpart of the debug unit's byte-serial dump: deserialises a UART byte stream
//  into 32-bit words and writes them into instruction memory.
//  Listens to the same rx_done_tick/rx_bus as the debug unit, reacts only to the 'L'/'l' command.
//  Holds the pipeline in reset while loading and answers with one status byte: 'K' = ok, 'E' = error.
// PARAMETERS
//  ADDR_W   8           instruction memory word-address width; capacity = 2**ADDR_W words
//  TIMEOUT  50_000_000  max top_clk cycles between consecutive rx bytes inside a frame
// PORTS
//  top_clk        in   1       single clock; everything is on its rising edge
//  top_rst        in   1       synchronous, active-high reset
//  rx_done_tick   in   1       one-cycle strobe: rx_bus holds a new byte
//  rx_bus         in   8       received byte
//  tx_done_tick   in   1       high = UART transmitter idle, tx_start may be pulsed
//  tx_start       out  1       one-cycle strobe: send tx_bus
//  tx_bus         out  8       status byte to send
//  mem_we         out  1       one-cycle instruction-memory write enable
//  mem_addr       out  ADDR_W  word address
//  mem_wdata      out  32      word to write
//  rst_pipe_hold  out  1       high for the whole load; OR'ed into the pipeline reset
//  load_busy      out  1       high in every state except IDLE
//  load_error     out  1       sticky error flag; cleared when the next 'L' is accepted
// BEHAVIOUR
//  Reset
//   - All outputs go to 0 and state goes to IDLE.
//   - Reset mid-frame aborts the frame. Words already written stay in memory.
//  Frame format: 'L', CNT_LO, CNT_HI, then N = {CNT_HI,CNT_LO} words of 4 bytes each
//   (LSB first, same order the debug unit uses), then one CSUM byte = XOR of all data bytes.
//  States
//   IDLE
//    - rx byte 'L'/'l' -> CNT_LO: rst_pipe_hold<=1, load_error<=0, checksum<=0, word index<=0.
//    - Any other byte is ignored (it belongs to the debug unit).
//   CNT_LO -> CNT_HI
//    - Latch the low count byte.
//   CNT_HI
//    - Latch the high count byte.
//    - N==0 or N>2**ADDR_W -> RESP with 'E'. Otherwise -> DATA.
//   DATA
//    - Each byte shifts into an assembly register; checksum ^= byte.
//    - On the 4th byte: mem_wdata and mem_addr = word index are registered, and mem_we = 1
//      the next cycle only (latency: 1 cycle after the 4th rx_done_tick). Word index increments.
//    - After word N-1 -> CSUM. Byte counter wraps 3->0.
//    - The word index never wraps, because N is bounded.
//   CSUM
//    - Received byte == checksum -> RESP with 'K' (0x4B); otherwise RESP with 'E' (0x45).
//    - On mismatch, already-written words are not rolled back.
//   RESP
//    - Waits for tx_done_tick=1, then tx_start=1 for one cycle with tx_bus valid the same cycle.
//    - Then: rst_pipe_hold<=0, load_error<=(byte=='E'), state -> IDLE.
//    - rx bytes arriving while in RESP are dropped.
//  Timeout
//   - Idle counter is cleared on every rx_done_tick and counts while in CNT_LO, CNT_HI, DATA, CSUM.
//   - Reaching TIMEOUT -> RESP with 'E'. A partial word is discarded and never written.
//   - Counter width = $clog2(TIMEOUT+1).
//  Simultaneous events
//   - top_rst has priority over everything.
//   - rx_done_tick in the same cycle the timeout expires: the byte wins and the counter resets.
//  Other rules
//   - mem_we is never asserted outside DATA.
//   - tx_start is never asserted outside RESP.
//   - tx_bus holds its value until the next response.
// TESTING
//  1. ADDR_W=8: 'L',02,00, 78 56 34 12, EF BE AD DE, 2A
//     -> mem_we @0=0x12345678, @1=0xDEADBEEF; tx 0x4B; load_error=0.
//  2. As test 1 but CSUM=2B -> both writes still occur; tx 0x45; load_error=1 until the next 'L'.
//  3. 'L',00,00 -> tx 'E', no mem_we.
//     'L',01,01 (257 > 256) -> tx 'E', no mem_we.
//  4. 'L',01,00, 78 56, then silence for TIMEOUT+1 cycles -> no mem_we; tx 'E'; IDLE;
//     rst_pipe_hold falls.
//  5. 's','c','r' bytes in IDLE -> no state change, no outputs.
//     tx_done_tick held 0 in RESP -> tx_start waits until it rises.
//  6. top_rst pulsed after 5 data bytes -> all outputs 0, IDLE.
//     A full test-1 frame afterwards succeeds with 'K'.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if
//   Groups the loader's UART and instruction-memory signals.
//   master : the loader (consumes rx/tx-idle, drives tx and memory write port)
//   slave  : the environment (UART rx/tx and instruction memory)
//   Signals: rx_done_tick/rx_bus (received byte strobe), tx_done_tick (tx idle),
//            tx_start/tx_bus (status byte), mem_we/mem_addr/mem_wdata (word write).
interface uart_program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_done_tick;
    logic [7:0]        rx_bus;
    logic              tx_done_tick;
    logic              tx_start;
    logic [7:0]        tx_bus;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_done_tick, rx_bus, tx_done_tick,
        output tx_start, tx_bus, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_done_tick, rx_bus, tx_done_tick,
        input  tx_start, tx_bus, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Deserialises an 'L'/'l' load frame from the UART byte stream into 32-bit
//   words, writes them to instruction memory and answers with 'K' or 'E'.
//   Frame: 'L', CNT_LO, CNT_HI, N words (4 bytes each, LSB first), CSUM (XOR of data).
//   Ports:
//     top_clk, top_rst     clock, synchronous active-high reset
//     bus (master)         rx byte strobe, tx handshake, memory write port
//     rst_pipe_hold        high for the whole load, OR'ed into pipeline reset
//     load_busy            high whenever the loader is not idle
//     load_error           sticky error of the last load, cleared by the next 'L'
//   ADDR_W must be <= 16 (frame count is 16 bits).
module uart_program_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic                         top_clk,
    input  logic                         top_rst,
    uart_program_loader_if.master        bus,
    output logic                         rst_pipe_hold,
    output logic                         load_busy,
    output logic                         load_error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, RESP} state_t;

    state_t            state, state_n;
    logic [7:0]        cnt_lo;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_q;       // first three bytes of the word being assembled
    logic [7:0]        csum;
    logic [TW-1:0]     tmo_cnt;

    logic load_start, cnt_lo_take, cnt_hi_take, byte_take, word_done;
    logic resp_go, resp_err, tx_fire;
    logic active, tmo_exp, last_word, n_bad;
    logic [15:0] n_in;

    assign n_in      = {bus.rx_bus, cnt_lo};
    assign n_bad     = (n_in == 16'd0) || ({1'b0, n_in} > 17'(2**ADDR_W));
    assign last_word = ({1'b0, n_words} == (17'(word_idx) + 17'd1));
    assign active    = (state == CNT_LO) || (state == CNT_HI) ||
                       (state == DATA)   || (state == CSUM);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_exp   = active && !bus.rx_done_tick && (tmo_cnt == TW'(TIMEOUT));

    assign load_busy    = (state != IDLE);
    assign bus.tx_start = tx_fire;

    always_comb begin
        state_n     = state;
        load_start  = 1'b0;
        cnt_lo_take = 1'b0;
        cnt_hi_take = 1'b0;
        byte_take   = 1'b0;
        word_done   = 1'b0;
        resp_go     = 1'b0;
        resp_err    = 1'b0;
        tx_fire     = 1'b0;
        case (state)
            IDLE: if (bus.rx_done_tick && (bus.rx_bus == 8'h4C || bus.rx_bus == 8'h6C)) begin
                load_start = 1'b1;
                state_n    = CNT_LO;
            end
            CNT_LO: if (bus.rx_done_tick) begin
                cnt_lo_take = 1'b1;
                state_n     = CNT_HI;
            end
            CNT_HI: if (bus.rx_done_tick) begin
                cnt_hi_take = 1'b1;
                if (n_bad) begin
                    resp_go  = 1'b1;
                    resp_err = 1'b1;
                    state_n  = RESP;
                end else begin
                    state_n  = DATA;
                end
            end
            DATA: if (bus.rx_done_tick) begin
                byte_take = 1'b1;
                if (byte_cnt == 2'd3) begin
                    word_done = 1'b1;
                    if (last_word) state_n = CSUM;
                end
            end
            CSUM: if (bus.rx_done_tick) begin
                resp_go  = 1'b1;
                resp_err = (bus.rx_bus != csum);
                state_n  = RESP;
            end
            // rx bytes are ignored here
            RESP: if (bus.tx_done_tick) begin
                tx_fire = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (tmo_exp) begin
            resp_go  = 1'b1;
            resp_err = 1'b1;
            state_n  = RESP;
        end
    end

    always_ff @(posedge top_clk) begin
        if (top_rst) begin
            state         <= IDLE;
            cnt_lo        <= '0;
            n_words       <= '0;
            word_idx      <= '0;
            byte_cnt      <= '0;
            asm_q         <= '0;
            csum          <= '0;
            tmo_cnt       <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.tx_bus    <= '0;
            rst_pipe_hold <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            state      <= state_n;
            bus.mem_we <= word_done;
            tmo_cnt    <= (bus.rx_done_tick || !active) ? '0 : tmo_cnt + TW'(1);
            if (load_start) begin
                rst_pipe_hold <= 1'b1;
                load_error    <= 1'b0;
                csum          <= '0;
                word_idx      <= '0;
                byte_cnt      <= '0;
            end
            if (cnt_lo_take) cnt_lo <= bus.rx_bus;
            if (cnt_hi_take) n_words <= n_in;
            if (byte_take) begin
                csum     <= csum ^ bus.rx_bus;
                byte_cnt <= byte_cnt + 2'd1;
                asm_q    <= {bus.rx_bus, asm_q[23:8]};
            end
            if (word_done) begin
                bus.mem_wdata <= {bus.rx_bus, asm_q};
                bus.mem_addr  <= word_idx;
                if (!last_word) word_idx <= word_idx + 1'b1;
            end
            if (resp_go) bus.tx_bus <= resp_err ? CH_E : CH_K;
            if (tx_fire) begin
                rst_pipe_hold <= 1'b0;
                load_error    <= (bus.tx_bus == CH_E);
            end
        end
    end
endmodule
